// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc sequencer: fetch FSM states, redirect
// opcodes and sticky fault codes.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StHalt
  } state_e;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of BUS_WIDTH-bit entries with full/empty flags.
// dout_o always shows the top entry; it is meaningless while empty_o is set.
module ras_stack #(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [BUS_WIDTH-1:0] din_i,
  output logic [BUS_WIDTH-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] FULL_COUNT = STACK_DEPTH[AW:0];

  logic [AW:0]          count_q, count_d;
  logic [BUS_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        top_idx;

  assign wr_idx  = count_q[AW-1:0];
  // Wraps to the last slot when the stack is exactly full.
  assign top_idx = count_q[AW-1:0] - 1'b1;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push_i && !full_o) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/redirect controller: sequences an external pc through fetch, wait and
// execute, handling jump/call/return redirects with a return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [BUS_WIDTH-1:0] pc_value_i,
  output logic                 pc_reset_o,
  output logic                 pc_inc_o,
  output logic                 pc_load_o,
  output logic [BUS_WIDTH-1:0] pc_in_o,
  output logic                 mem_req_o,
  output logic [BUS_WIDTH-1:0] mem_addr_o,
  input  logic                 mem_ready_i,
  input  logic [BUS_WIDTH-1:0] mem_rdata_i,
  output logic [BUS_WIDTH-1:0] instr_o,
  output logic                 instr_valid_o,
  input  logic                 exec_done_i,
  input  logic [1:0]           redirect_op_i,
  input  logic [BUS_WIDTH-1:0] redirect_target_i,
  input  logic                 halt_req_i,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic [1:0]           fault_o,
  output logic [BUS_WIDTH-1:0] retired_o
);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [BUS_WIDTH-1:0] retired_q, retired_d;
  logic [1:0]           fault_q, fault_d;

  logic                 push, pop;
  logic                 stk_full, stk_empty;
  logic [BUS_WIDTH-1:0] stk_dout;
  logic [BUS_WIDTH-1:0] ret_addr;
  logic                 op_ok;
  logic [1:0]           op_fault;

  assign ret_addr = pc_value_i + 1'b1;

  ras_stack #(
    .BUS_WIDTH  (BUS_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ras_stack (
    .clk_i  (clock_i),
    .reset_i(reset_i),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (ret_addr),
    .dout_o (stk_dout),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = fault_q;
    pc_inc_o      = 1'b0;
    pc_load_o     = 1'b0;
    pc_in_o       = '0;
    push          = 1'b0;
    pop           = 1'b0;
    op_ok         = 1'b0;
    op_fault      = FAULT_NONE;

    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: state_d = StWait;
      StWait: begin
        if (mem_ready_i) begin
          instr_d       = mem_rdata_i;
          instr_valid_d = 1'b1;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (exec_done_i) begin
          case (redirect_op_i)
            OP_NEXT: begin
              pc_inc_o = 1'b1;
              op_ok    = 1'b1;
            end
            OP_JUMP: begin
              pc_load_o = 1'b1;
              pc_in_o   = redirect_target_i;
              op_ok     = 1'b1;
            end
            OP_CALL: begin
              if (stk_full) begin
                op_fault = FAULT_OVERFLOW;
              end else begin
                push      = 1'b1;
                pc_load_o = 1'b1;
                pc_in_o   = redirect_target_i;
                op_ok     = 1'b1;
              end
            end
            default: begin
              if (stk_empty) begin
                op_fault = FAULT_UNDERFLOW;
              end else begin
                pop       = 1'b1;
                pc_load_o = 1'b1;
                pc_in_o   = stk_dout;
                op_ok     = 1'b1;
              end
            end
          endcase
          if (op_ok) begin
            state_d = halt_req_i ? StHalt : StFetch;
          end else begin
            // The first fault recorded is kept until reset.
            if (fault_q == FAULT_NONE) fault_d = op_fault;
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset aborts any in-flight redirect so the pc is left untouched.
    if (reset_i) begin
      pc_inc_o  = 1'b0;
      pc_load_o = 1'b0;
      pc_in_o   = '0;
      push      = 1'b0;
      pop       = 1'b0;
      op_ok     = 1'b0;
    end
  end

  assign retired_d = retired_q + {{(BUS_WIDTH-1){1'b0}}, op_ok};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
      fault_q       <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
      fault_q       <= fault_d;
    end
  end

  assign pc_reset_o    = (state_q == StIdle);
  assign mem_req_o     = (state_q == StFetch) || (state_q == StWait);
  assign mem_addr_o    = mem_req_o ? pc_value_i : '0;
  assign busy_o        = (state_q == StFetch) || (state_q == StWait) || (state_q == StExec);
  assign halted_o      = (state_q == StHalt);
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fault_o       = fault_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: instruction-level model with a queue-based stack and
// a bench-owned pc register, directed scenarios followed by random stimulus.
module tb_pc_sequencer;

  localparam int DEPTH = 8;
  localparam int S_IDLE = 0, S_FETCH = 1, S_WAIT = 2, S_EXEC = 3, S_HALT = 4;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready, exec_done, halt_req;
  logic [15:0] pc_value, mem_rdata, redirect_target;
  logic [1:0]  redirect_op;
  logic        pc_reset, pc_inc, pc_load, mem_req, instr_valid, busy, halted;
  logic [15:0] pc_in, mem_addr, instr, retired;
  logic [1:0]  fault;

  always #5 clk = ~clk;

  pc_sequencer #(
    .BUS_WIDTH  (16),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .start_i          (start),
    .pc_value_i       (pc_value),
    .pc_reset_o       (pc_reset),
    .pc_inc_o         (pc_inc),
    .pc_load_o        (pc_load),
    .pc_in_o          (pc_in),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_ready_i      (mem_ready),
    .mem_rdata_i      (mem_rdata),
    .instr_o          (instr),
    .instr_valid_o    (instr_valid),
    .exec_done_i      (exec_done),
    .redirect_op_i    (redirect_op),
    .redirect_target_i(redirect_target),
    .halt_req_i       (halt_req),
    .busy_o           (busy),
    .halted_o         (halted),
    .fault_o          (fault),
    .retired_o        (retired)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int          m_st = S_IDLE;
  logic [15:0] m_stack[$];
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_ret = 16'h0;
  logic        m_iv = 1'b0;
  logic [1:0]  m_fault = 2'b00;
  logic        m_valid = 1'b0;

  // DUT outputs captured mid-cycle for literal checks
  logic        s_pc_reset, s_pc_inc, s_pc_load, s_mem_req;
  logic [15:0] s_pc_in, s_mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic mr, input logic [15:0] rd,
                     input logic ed, input logic [1:0] op, input logic [15:0] tgt,
                     input logic hr);
    logic        e_reset, e_inc, e_load, e_req, e_busy, e_halted, ok;
    logic [15:0] e_pcin, n_pc;
    logic [1:0]  code;
    @(negedge clk);
    rst = r; start = s; mem_ready = mr; mem_rdata = rd; exec_done = ed;
    redirect_op = op; redirect_target = tgt; halt_req = hr; pc_value = m_pc;
    #1;
    e_reset  = (m_st == S_IDLE);
    e_req    = (m_st == S_FETCH) || (m_st == S_WAIT);
    e_busy   = e_req || (m_st == S_EXEC);
    e_halted = (m_st == S_HALT);
    e_inc = 1'b0; e_load = 1'b0; e_pcin = 16'h0; ok = 1'b0; code = 2'b00;
    if (!r && m_st == S_EXEC && ed) begin
      case (op)
        2'd0: begin e_inc = 1'b1; ok = 1'b1; end
        2'd1: begin e_load = 1'b1; e_pcin = tgt; ok = 1'b1; end
        2'd2: if (m_stack.size() < DEPTH) begin e_load = 1'b1; e_pcin = tgt; ok = 1'b1; end
              else code = 2'b01;
        default: if (m_stack.size() > 0) begin e_load = 1'b1; e_pcin = m_stack[$]; ok = 1'b1; end
                 else code = 2'b10;
      endcase
    end
    if (m_valid) begin
      chk("pc_reset", 32'(pc_reset), 32'(e_reset));
      chk("pc_inc", 32'(pc_inc), 32'(e_inc));
      chk("pc_load", 32'(pc_load), 32'(e_load));
      chk("pc_in", 32'(pc_in), 32'(e_pcin));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      if (e_req) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("instr", 32'(instr), 32'(m_instr));
      chk("instr_valid", 32'(instr_valid), 32'(m_iv));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("halted", 32'(halted), 32'(e_halted));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("retired", 32'(retired), 32'(m_ret));
    end
    s_pc_reset = pc_reset; s_pc_inc = pc_inc; s_pc_load = pc_load;
    s_mem_req = mem_req; s_pc_in = pc_in; s_mem_addr = mem_addr;

    // Bench-owned pc register follows the expected controls.
    n_pc = e_reset ? 16'h0 : e_load ? e_pcin : e_inc ? m_pc + 16'd1 : m_pc;
    if (r) begin
      m_st = S_IDLE; m_stack.delete(); m_instr = 16'h0; m_iv = 1'b0;
      m_ret = 16'h0; m_fault = 2'b00; m_valid = 1'b1;
    end else begin
      m_iv = 1'b0;
      case (m_st)
        S_IDLE:  if (s) m_st = S_FETCH;
        S_FETCH: m_st = S_WAIT;
        S_WAIT:  if (mr) begin m_instr = rd; m_iv = 1'b1; m_st = S_EXEC; end
        S_EXEC: if (ed) begin
          if (ok) begin
            if (op == 2'd2) m_stack.push_back(m_pc + 16'd1);
            if (op == 2'd3) void'(m_stack.pop_back());
            m_ret = m_ret + 16'd1;
            m_st = hr ? S_HALT : S_FETCH;
          end else begin
            if (m_fault == 2'b00) m_fault = code;
            m_st = S_HALT;
          end
        end
        default: if (s) m_st = S_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    m_pc = n_pc;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic do_start();
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  // One full fetch/wait/exec pass; s_* hold the exec-cycle outputs afterwards.
  task automatic instr3(input logic [1:0] op, input logic [15:0] tgt, input logic hr);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 16'(op) + 16'h0A00, 1'b0, 2'd0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, op, tgt, hr);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    pc_value = 16'h0; mem_rdata = 16'h0; redirect_target = 16'h0; redirect_op = 2'd0;

    // Reset for two cycles, then three back-to-back NEXT instructions.
    do_reset();
    do_reset();
    chk("lit_idle_pc_reset", 32'(s_pc_reset), 32'd1);
    do_start();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 2'd0, 16'h0, 1'b0);
      if (i % 3 == 0) chk("lit_fetch_addr", 32'(s_mem_addr), 32'(i / 3));
      chk("lit_inc_cadence", 32'(s_pc_inc), (i % 3 == 2) ? 32'd1 : 32'd0);
    end
    chk("lit_retired3", 32'(retired), 32'd3);

    // Memory stall in WAIT.
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 2'd0, 16'h0, 1'b0);
      chk("lit_stall_req", 32'(s_mem_req), 32'd1);
      chk("lit_stall_noinc", 32'(s_pc_inc), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("lit_instr", 32'(instr), 32'h1234);
    chk("lit_instr_valid", 32'(instr_valid), 32'd1);
    idle();
    chk("lit_instr_valid_pulse", 32'(instr_valid), 32'd0);

    // Jump to 5, CALL 511, RET to 6, then RET on empty stack.
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 2'd1, 16'd5, 1'b0);
    instr3(2'd2, 16'd511, 1'b0);
    chk("lit_call_load", 32'(s_pc_load), 32'd1);
    chk("lit_call_target", 32'(s_pc_in), 32'd511);
    instr3(2'd3, 16'h0, 1'b0);
    chk("lit_ret_addr", 32'(s_pc_in), 32'd6);
    instr3(2'd3, 16'h0, 1'b0);
    chk("lit_underflow_noload", 32'(s_pc_load), 32'd0);
    chk("lit_underflow_fault", 32'(fault), 32'b10);
    chk("lit_underflow_halted", 32'(halted), 32'd1);

    // Fill the stack to DEPTH, then overflow.
    do_reset();
    do_start();
    for (int k = 0; k < DEPTH; k++) instr3(2'd2, 16'h0100 + 16'(k), 1'b0);
    chk("lit_call8_fault", 32'(fault), 32'b00);
    instr3(2'd2, 16'h0200, 1'b0);
    chk("lit_overflow_noload", 32'(s_pc_load), 32'd0);
    chk("lit_overflow_fault", 32'(fault), 32'b01);
    chk("lit_overflow_halted", 32'(halted), 32'd1);

    // pc wrap and return-address wrap.
    do_reset();
    do_start();
    instr3(2'd1, 16'hFFFF, 1'b0);
    instr3(2'd0, 16'h0, 1'b0);
    idle();
    chk("lit_wrap_addr", 32'(s_mem_addr), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 2'd1, 16'hFFFF, 1'b0);
    instr3(2'd2, 16'h0020, 1'b0);
    instr3(2'd3, 16'h0, 1'b0);
    chk("lit_wrap_ret_load", 32'(s_pc_load), 32'd1);
    chk("lit_wrap_ret_addr", 32'(s_pc_in), 32'd0);

    // Reset during an exec_done JUMP with a non-empty stack.
    instr3(2'd2, 16'h0030, 1'b0);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 2'd1, 16'd77, 1'b0);
    chk("lit_rst_noload", 32'(s_pc_load), 32'd0);
    chk("lit_rst_retired", 32'(retired), 32'd0);
    chk("lit_rst_fault", 32'(fault), 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    do_start();
    instr3(2'd3, 16'h0, 1'b0);
    chk("lit_rst_stack_empty", 32'(fault), 32'b10);

    // halt_req after a NEXT, then back to IDLE.
    do_start();
    do_start();
    instr3(2'd0, 16'h0, 1'b1);
    chk("lit_halt_inc", 32'(s_pc_inc), 32'd1);
    chk("lit_halt_halted", 32'(halted), 32'd1);
    do_start();
    idle();
    chk("lit_halt_idle_reset", 32'(s_pc_reset), 32'd1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] op;
      int         r;
      r  = $urandom_range(9);
      op = (r < 4) ? 2'd2 : (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'd3;
      cyc(($urandom_range(99) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
          16'($urandom), 1'($urandom_range(1)), op, 16'($urandom),
          ($urandom_range(7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/redirect controller that sequences the program counter.
- Drives the pc control inputs (reset, inc, load, load value) from a fetch FSM, an instruction-memory request/ready handshake and redirect commands from the execute stage.
- Holds a return-address stack for call/return.
- Sits between the pc, instruction memory and the decode/execute unit.

Parameters:
- BUS_WIDTH, 16, width of pc value, addresses, instruction word and retired counter.
- STACK_DEPTH, 8, return-address stack entries; power of two, ≥2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE/HALT.
- pc_value  in  BUS_WIDTH  current pc output.
- pc_reset  out  1  pc reset control.
- pc_inc  out  1  pc increment control.
- pc_load  out  1  pc load control.
- pc_in  out  BUS_WIDTH  pc load value.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  BUS_WIDTH  fetch address.
- mem_ready  in  1  fetch data valid.
- mem_rdata  in  BUS_WIDTH  fetched instruction.
- instr  out  BUS_WIDTH  instruction register.
- instr_valid  out  1  one-cycle pulse, new instr captured.
- exec_done  in  1  execute stage finished current instr.
- redirect_op  in  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET; sampled only with exec_done.
- redirect_target  in  BUS_WIDTH  target for JUMP/CALL.
- halt_req  in  1  stop after current instr; sampled with exec_done.
- busy  out  1  state is FETCH, WAIT or EXEC.
- halted  out  1  state is HALT.
- fault  out  2  sticky: 01 stack overflow, 10 stack underflow, 00 none.
- retired  out  BUS_WIDTH  retired-instruction count; wraps modulo 2^BUS_WIDTH.

Behaviour:
- Reset (synchronous, active-high): state IDLE; stack pointer 0; instr 0; retired 0; fault 00.
  - Registered outputs take the values above.
  - Combinational outputs decode from IDLE: pc_reset=1; pc_inc, pc_load, mem_req, instr_valid, busy, halted=0; pc_in=0.
  - Reset in any state, mid-fetch or mid-exec, aborts immediately with no pc update.
- pc_inc and pc_load are never both 1.
- pc_in=0 whenever pc_load=0.
- IDLE: pc_reset=1 (holds pc at 0). start → FETCH.
- FETCH (1 cycle): mem_req=1, mem_addr=pc_value → WAIT.
- WAIT: mem_req=1, mem_addr=pc_value held.
  - mem_ready=1: instr<=mem_rdata, instr_valid=1 next cycle, → EXEC.
  - Otherwise stay, unbounded.
- EXEC: wait for exec_done; no pc control asserted until then. In the exec_done cycle:
  - NEXT: pc_inc=1.
  - JUMP: pc_load=1, pc_in=redirect_target.
  - CALL: stack not full → push (pc_value+1) mod 2^BUS_WIDTH, pc_load=1, pc_in=redirect_target. Stack full → no push, no pc control, fault<=01, → HALT.
  - RET: stack not empty → pop, pc_load=1, pc_in=popped value. Stack empty → no pc control, fault<=10, → HALT.
  - On a successful op: retired += 1. Then halt_req=1 → HALT, else → FETCH.
  - The pc updates on the same edge, so the next FETCH sees the new pc_value.
- Minimum throughput: 3 cycles/instr (mem_ready and exec_done high at first opportunity).
- HALT: halted=1, no pc control. start → IDLE; fault stays sticky until reset.
- Stack:
  - Full when count==STACK_DEPTH, empty when count==0.
  - CALL can fill to exactly STACK_DEPTH entries.
  - LIFO order.
- Inputs outside their sampling state are ignored (exec_done outside EXEC, mem_ready outside WAIT).

Decomposition:
- Shared package pc_seq_pkg:
  - state encoding IDLE/FETCH/WAIT/EXEC/HALT;
  - redirect_op constants OP_NEXT/OP_JUMP/OP_CALL/OP_RET;
  - fault codes.
- One sub-module: ras_stack.
  - Parameters: BUS_WIDTH, STACK_DEPTH.
  - Interface: push, pop, din, dout, full, empty, synchronous reset.
- FSM, pc-control decode and retired counter stay in the top module.

Test Plan:
- reset held 2 cycles, then start with mem_ready=1, exec_done=1, op NEXT ×3 → pc_reset=1 in IDLE; pc_inc pulses every 3rd cycle; mem_addr 0,1,2; retired=3.
- mem_ready held low 4 cycles in WAIT with mem_rdata=16'h1234 → mem_req stays 1, no pc_inc; then instr=16'h1234, one instr_valid pulse.
- pc=5, CALL target 511 → pc_load=1, pc_in=511. Then RET → pc_in=6, stack empty.
- STACK_DEPTH=8: 8 CALLs succeed; 9th CALL → no pc_load, fault=01, halted=1. Separately, RET on empty → fault=10, halted=1.
- JUMP target 16'hFFFF then NEXT → pc wraps to 0; CALL at pc 16'hFFFF pushes 0.
- reset asserted in EXEC while exec_done=1 with op JUMP → no pc_load, state IDLE, retired=0, fault=00, stack empty.
- halt_req=1 with exec_done → HALT after the pc update; start → IDLE, pc_reset=1.
